if_id_fetch_queue: RTL and testbench
====================================

Name: if_id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry FIFO between fetch and decode.
- Lets fetch keep running while ID is stalled by a hazard or bubble.
- Presents a NOP bubble to ID when the queue is empty.
- Supports a one-cycle flush for SYSCALL/ERET and exception redirect.

Parameters:
INS_W, 32, instruction width in bits
PC_W, 30, word-address PC width (byte address bits 31:2)
DEPTH, 4, number of entries; power of 2, minimum 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
in_valid  input  1  fetch offers an instruction this cycle
in_ready  output  1  queue accepts an instruction this cycle
in_ins  input  INS_W  fetched instruction
in_pc  input  PC_W  word PC of the fetched instruction
stall  input  1  ID cannot consume (hazard, branch bubble or cp0 bubble)
flush  input  1  discard all entries (SYSCALL, ERET, exception redirect)
out_valid  output  1  head entry is valid
out_ins  output  INS_W  head instruction; all-zero (NOP) when out_valid=0
out_pc  output  PC_W  head PC; 0 when out_valid=0
out_pc_plus_4  output  PC_W  out_pc+1 modulo 2^PC_W; 0 when out_valid=0
count  output  CNT_W  number of occupied entries, 0..DEPTH

Behaviour:
- Storage: circular buffer with write pointer wp, read pointer rp and occupancy count. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset low (asynchronous):
  - wp=0, rp=0, count=0.
  - Therefore out_valid=0, out_ins=0, out_pc=0, out_pc_plus_4=0, in_ready=1.
  - Storage array contents are don't-care and are never visible at the outputs.
- in_ready = (count != DEPTH). It is purely a function of state and has no combinational path from stall or flush.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & ~stall & ~flush.
- out_valid = (count != 0).
- out_ins and out_pc are driven combinationally from entry[rp], gated to 0 when out_valid=0.
- Latency: an instruction pushed at edge N appears at out_* after edge N if the queue was empty. There is no same-cycle bypass.
- Clock edge, no flush:
  - push writes entry[wp] and increments wp.
  - pop increments rp.
  - count += push - pop.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count between 1 and DEPTH-1.
- Full (count==DEPTH): in_ready=0, so no push occurs. A pop in that cycle frees one slot, and in_ready rises on the next cycle.
- Empty (count==0): out_valid=0, so ID sees a NOP. stall has no effect.
- stall=1: head is held and out_* are stable. Pushes continue until the queue is full.
- flush=1 at an edge:
  - rp=wp=0 and count=0.
  - Any push or pop that cycle is discarded.
  - flush takes priority over stall, push and pop.
  - On the next cycle out_valid=0 (NOP) and in_ready=1.
- A branch or jump does not flush. The delay-slot instruction is always delivered.
- Reset asserted mid-operation clears state immediately. Outputs go to their reset values without waiting for a clock edge.
- out_pc_plus_4 wraps: out_pc=2^PC_W-1 gives out_pc_plus_4=0.
- count never exceeds DEPTH and never underflows. Any such violation is a bench assertion failure.

Test Plan:
1. Fill and drain: stall=1, push PCs 0x100..0x103 (ins 0xA0..0xA3).
   - Required: count=4, in_ready=0; out_pc stays 0x100.
   - Then release stall: out_pc steps 0x100, 0x101, 0x102, 0x103 on consecutive cycles, then out_valid=0 with out_ins=0.
2. Streaming at count=2: in_valid=1 and stall=0 every cycle.
   - Required: count stays 2 and the output order matches push order.
   - Run 10 entries so both pointers wrap at least twice.
3. Flush priority: count=3, stall=1, in_valid=1, flush=1 for one cycle.
   - Required: count=0 next cycle, out_valid=0, out_ins=0, in_ready=1.
   - The instruction offered in the flush cycle is never output.
4. Full plus pop: count=DEPTH, stall drops for one cycle while in_valid=1.
   - Required: in_ready=0 in that cycle and the push is not accepted.
   - Next cycle count=DEPTH-1 and in_ready=1.
5. Asynchronous reset: assert Reset=0 between clock edges with count=3.
   - Required: count=0 and all out_* equal 0 before the next edge.
   - After release, the first push is output one cycle later.
6. PC wrap: push in_pc=0x3FFFFFFF.
   - Required: out_pc=0x3FFFFFFF and out_pc_plus_4=0x00000000.

Source files
------------

// File: rtl/if_id_fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch/ID control in, head entry out.
// master = fetch/ID side, slave = the queue.
interface if_id_fetch_queue_if #(
   parameter int INS_W = 32,
   parameter int PC_W  = 30,
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [INS_W-1:0] in_ins;
   logic [PC_W-1:0]  in_pc;
   logic             stall;
   logic             flush;
   logic             out_valid;
   logic [INS_W-1:0] out_ins;
   logic [PC_W-1:0]  out_pc;
   logic [PC_W-1:0]  out_pc_plus_4;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_ins, in_pc, stall, flush,
      input  in_ready, out_valid, out_ins, out_pc,
      input  out_pc_plus_4, count
   );

   modport slave (
      input  in_valid, in_ins, in_pc, stall, flush,
      output in_ready, out_valid, out_ins, out_pc,
      output out_pc_plus_4, count
   );
endinterface

// File: rtl/if_id_fetch_queue.sv
// DEPTH-entry IF/ID fetch queue; NOP bubble when empty,
// one-cycle flush for SYSCALL/ERET/exception redirect.
module if_id_fetch_queue #(
   parameter int INS_W = 32,
   parameter int PC_W  = 30,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input logic Clk,
   input logic Reset,
   if_id_fetch_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic [CNT_W-1:0] cnt;
   logic [INS_W-1:0] ins_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem  [DEPTH];
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign push  = q.in_valid & ~full & ~q.flush;
   assign pop   = ~empty & ~q.stall & ~q.flush;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (q.flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push)
            wp <= wp + PTR_W'(1);
         if (pop)
            rp <= rp + PTR_W'(1);
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is never reset; the empty gate hides stale data.
   always_ff @(posedge Clk) begin
      if (push) begin
         ins_mem[wp] <= q.in_ins;
         pc_mem[wp]  <= q.in_pc;
      end
   end

   assign q.in_ready      = ~full;
   assign q.out_valid     = ~empty;
   assign q.out_ins       = empty ? '0 : ins_mem[rp];
   assign q.out_pc        = empty ? '0 : pc_mem[rp];
   assign q.out_pc_plus_4 = empty ? '0 : pc_mem[rp] + PC_W'(1);
   assign q.count         = cnt;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue: fill/drain, streaming,
// flush, full+pop, async reset, PC wrap.
module tb_if_id_fetch_queue;
   localparam int INS_W = 32;
   localparam int PC_W  = 30;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic Clk;
   logic Reset;
   int   errors = 0;
   int   checks = 0;

   if_id_fetch_queue_if #(
      .INS_W(INS_W), .PC_W(PC_W), .CNT_W(CNT_W)
   ) q ();

   if_id_fetch_queue #(
      .INS_W(INS_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .q(q)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Occupancy must stay within 0..DEPTH at every sample point.
   always @(negedge Clk) begin
      if (Reset) begin
         checks++;
         if (q.count > CNT_W'(DEPTH)) begin
            errors++;
            $display("FAIL count_bound: count=%0d limit=%0d",
                     q.count, DEPTH);
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      q.in_valid = 1'b0;
      q.in_ins   = '0;
      q.in_pc    = '0;
      q.stall    = 1'b0;
      q.flush    = 1'b0;
   endtask

   task automatic do_flush();
      q.in_valid = 1'b0;
      q.flush    = 1'b1;
      step();
      q.flush    = 1'b0;
   endtask

   task automatic fill(input logic [PC_W-1:0] pc0,
                       input logic [INS_W-1:0] ins0,
                       input int n);
      q.stall    = 1'b1;
      q.in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         q.in_pc  = pc0 + PC_W'(i);
         q.in_ins = ins0 + INS_W'(i);
         step();
      end
      q.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      idle();
      #3;
      checks++;
      if (q.count !== 3'd0 || q.out_valid !== 1'b0 ||
          q.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctl: cnt=%0d ov=%b ir=%b need 0/0/1",
                  q.count, q.out_valid, q.in_ready);
      end
      checks++;
      if (q.out_ins !== 32'h0 || q.out_pc !== 30'h0 ||
          q.out_pc_plus_4 !== 30'h0) begin
         errors++;
         $display("FAIL reset_out: ins=%h pc=%h pc4=%h need 0",
                  q.out_ins, q.out_pc, q.out_pc_plus_4);
      end
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      step();
   endtask

   task automatic test_fill_drain();
      q.stall    = 1'b1;
      q.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         q.in_pc  = 30'h100 + 30'(i);
         q.in_ins = 32'hA0 + 32'(i);
         step();
         checks++;
         if (q.out_pc !== 30'h100) begin
            errors++;
            $display("FAIL fill_head[%0d]: pc=%h need 100",
                     i, q.out_pc);
         end
      end
      checks++;
      if (q.count !== 3'd4 || q.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: cnt=%0d ir=%b need 4/0",
                  q.count, q.in_ready);
      end
      step();
      checks++;
      if (q.out_pc !== 30'h100 || q.count !== 3'd4) begin
         errors++;
         $display("FAIL fill_hold: pc=%h cnt=%0d need 100/4",
                  q.out_pc, q.count);
      end
      q.in_valid = 1'b0;
      q.stall    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q.out_valid !== 1'b1 ||
             q.out_pc !== 30'h100 + 30'(i) ||
             q.out_ins !== 32'hA0 + 32'(i) ||
             q.out_pc_plus_4 !== 30'h101 + 30'(i)) begin
            errors++;
            $display("FAIL drain[%0d]: v=%b pc=%h ins=%h pc4=%h",
                     i, q.out_valid, q.out_pc, q.out_ins,
                     q.out_pc_plus_4);
         end
         step();
      end
      checks++;
      if (q.out_valid !== 1'b0 || q.out_ins !== 32'h0 ||
          q.count !== 3'd0) begin
         errors++;
         $display("FAIL drain_empty: v=%b ins=%h cnt=%0d need 0",
                  q.out_valid, q.out_ins, q.count);
      end
   endtask

   task automatic test_streaming();
      fill(30'h200, 32'hB00, 2);
      q.stall    = 1'b0;
      q.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         q.in_pc  = 30'h202 + 30'(k);
         q.in_ins = 32'hB02 + 32'(k);
         checks++;
         if (q.count !== 3'd2 || q.out_pc !== 30'h200 + 30'(k) ||
             q.out_ins !== 32'hB00 + 32'(k)) begin
            errors++;
            $display("FAIL stream[%0d]: cnt=%0d pc=%h ins=%h",
                     k, q.count, q.out_pc, q.out_ins);
         end
         step();
      end
      q.in_valid = 1'b0;
      for (int k = 10; k < 12; k++) begin
         checks++;
         if (q.out_pc !== 30'h200 + 30'(k)) begin
            errors++;
            $display("FAIL stream_tail[%0d]: pc=%h need %h",
                     k, q.out_pc, 30'h200 + 30'(k));
         end
         step();
      end
      checks++;
      if (q.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_empty: v=%b need 0", q.out_valid);
      end
   endtask

   task automatic test_flush();
      fill(30'h300, 32'hC00, 3);
      q.stall    = 1'b1;
      q.in_valid = 1'b1;
      q.in_pc    = 30'h3FF;
      q.in_ins   = 32'hDEAD;
      q.flush    = 1'b1;
      step();
      q.flush    = 1'b0;
      q.in_valid = 1'b0;
      checks++;
      if (q.count !== 3'd0 || q.out_valid !== 1'b0 ||
          q.out_ins !== 32'h0 || q.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush: cnt=%0d v=%b ins=%h ir=%b",
                  q.count, q.out_valid, q.out_ins, q.in_ready);
      end
      q.stall = 1'b0;
      step();
      step();
      checks++;
      if (q.out_valid !== 1'b0 || q.out_pc !== 30'h0) begin
         errors++;
         $display("FAIL flush_drop: v=%b pc=%h need 0/0",
                  q.out_valid, q.out_pc);
      end
   endtask

   task automatic test_full_pop();
      fill(30'h400, 32'hD00, 4);
      q.stall    = 1'b0;
      q.in_valid = 1'b1;
      q.in_pc    = 30'h4FF;
      q.in_ins   = 32'hBAD;
      checks++;
      if (q.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: ir=%b need 0", q.in_ready);
      end
      step();
      q.stall    = 1'b1;
      q.in_valid = 1'b0;
      checks++;
      if (q.count !== 3'd3 || q.in_ready !== 1'b1 ||
          q.out_pc !== 30'h401) begin
         errors++;
         $display("FAIL full_pop: cnt=%0d ir=%b pc=%h need 3/1/401",
                  q.count, q.in_ready, q.out_pc);
      end
      q.stall = 1'b0;
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (q.out_pc !== 30'h400 + 30'(i)) begin
            errors++;
            $display("FAIL full_drain[%0d]: pc=%h need %h",
                     i, q.out_pc, 30'h400 + 30'(i));
         end
         step();
      end
      checks++;
      if (q.out_valid !== 1'b0 || q.count !== 3'd0) begin
         errors++;
         $display("FAIL full_nopush: v=%b cnt=%0d need 0/0",
                  q.out_valid, q.count);
      end
   endtask

   task automatic test_async_reset();
      fill(30'h500, 32'hE00, 3);
      #2;
      Reset = 1'b0;
      #1;
      checks++;
      if (q.count !== 3'd0 || q.out_valid !== 1'b0 ||
          q.out_ins !== 32'h0 || q.out_pc !== 30'h0 ||
          q.out_pc_plus_4 !== 30'h0 || q.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_rst: cnt=%0d v=%b ins=%h pc=%h ir=%b",
                  q.count, q.out_valid, q.out_ins, q.out_pc,
                  q.in_ready);
      end
      #1;
      Reset      = 1'b1;
      q.stall    = 1'b0;
      q.in_valid = 1'b1;
      q.in_pc    = 30'h5A0;
      q.in_ins   = 32'hE5A0;
      step();
      q.in_valid = 1'b0;
      checks++;
      if (q.out_valid !== 1'b1 || q.out_pc !== 30'h5A0 ||
          q.out_ins !== 32'hE5A0) begin
         errors++;
         $display("FAIL rst_push: v=%b pc=%h ins=%h need 1/5a0",
                  q.out_valid, q.out_pc, q.out_ins);
      end
      step();
   endtask

   task automatic test_pc_wrap();
      q.stall    = 1'b1;
      q.in_valid = 1'b1;
      q.in_pc    = 30'h3FFFFFFF;
      q.in_ins   = 32'h12345678;
      step();
      q.in_valid = 1'b0;
      checks++;
      if (q.out_pc !== 30'h3FFFFFFF || q.out_pc_plus_4 !== 30'h0 ||
          q.out_ins !== 32'h12345678) begin
         errors++;
         $display("FAIL pc_wrap: pc=%h pc4=%h ins=%h",
                  q.out_pc, q.out_pc_plus_4, q.out_ins);
      end
      do_flush();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_streaming();
      test_flush();
      test_full_pop();
      test_async_reset();
      test_pc_wrap();
      idle();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
